gsensor_axis_reader: RTL and testbench

- Parametrised accelerometer configuration and sampling sequencer for the G-sensor path.
- After reset it writes a programmable register-initialisation table to the sensor, then polls the interrupt-source register on INT2 or on an idle timeout. When the data-ready bit is set, it burst-reads NUM_AXES little-endian 16-bit samples and publishes them atomically with a one-cycle valid strobe.
- It drives an external byte-level SPI controller through a GO/END handshake and sits between that controller and the display/consumer logic.

---
 rtl/gsensor_axis_reader.sv | 161 ++++++++++++++++
 tb/tb_gsensor_axis_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gsensor_axis_reader.sv
// gsensor_axis_reader: writes the sensor init table over SPI, then polls on INT2 or an idle timeout
// and burst-reads NUM_AXES 16-bit samples, publishing them atomically with a one-cycle strobe.
module gsensor_axis_reader #(
    parameter int NUM_AXES = 3,
    parameter int INI_NUMBER = 11,
    parameter logic [223:0] INIT_TABLE = 224'h0,
    parameter logic [5:0] DATA_BASE = 6'h32,
    parameter logic [5:0] INT_SOURCE_ADDR = 6'h30,
    parameter int DRDY_BIT = 7,
    parameter int IDLE_MSB = 14,
    parameter int INT_MASK = 4
) (
    input  logic iSPI_CLK,
    input  logic iRST,
    input  logic iREINIT,
    input  logic iG_INT2,
    output logic [15:0] oP2S_DATA,
    output logic oSPI_GO,
    input  logic iSPI_END,
    input  logic [7:0] iS2P_DATA,
    output logic [16*NUM_AXES-1:0] oDATA,
    output logic oVALID,
    output logic oINIT_DONE
);
    localparam int DW = 16 * NUM_AXES;
    localparam int CW = IDLE_MSB + 1;
    localparam int MW = $clog2(INT_MASK + 2);
    localparam logic [3:0] LAST_IDX = 4'(INI_NUMBER - 1);
    localparam logic [2:0] LAST_J = 3'(2 * NUM_AXES - 1);

    typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, STAT_WAIT, RD_ISSUE, RD_WAIT, PUBLISH} state_t;

    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] j_q, j_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mask_q, mask_d;
    logic pend_q, pend_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [15:0] p2s_q, p2s_d;
    logic go_q, go_d;
    logic [DW-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic done_q, done_d;
    logic restart;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        j_d = j_q;
        cnt_d = cnt_q;
        mask_d = (mask_q != '0) ? mask_q - MW'(1) : mask_q;
        pend_d = pend_q | iREINIT;
        shadow_d = shadow_q;
        p2s_d = p2s_q;
        go_d = go_q;
        data_d = data_q;
        valid_d = 1'b0;
        done_d = done_q;
        restart = 1'b0;
        case (state_q)
            INIT_ISSUE: begin
                restart = pend_d;
                if (!pend_d && !iSPI_END) begin
                    p2s_d = {2'b00, INIT_TABLE[14*idx_q +: 14]};
                    go_d = 1'b1;
                    state_d = INIT_WAIT;
                end
            end
            INIT_WAIT: if (iSPI_END) begin
                go_d = 1'b0;
                idx_d = idx_q + 4'd1;
                done_d = idx_q == LAST_IDX;
                state_d = (idx_q == LAST_IDX) ? IDLE : INIT_ISSUE;
                restart = pend_d;
            end
            IDLE: begin
                // counter saturates so a poll blocked by a lingering END still fires later
                cnt_d = cnt_q + CW'(!cnt_q[IDLE_MSB]);
                restart = pend_d;
                if (!pend_d && ((iG_INT2 && mask_q == '0) || cnt_q[IDLE_MSB]) && !iSPI_END) begin
                    p2s_d = {2'b10, INT_SOURCE_ADDR, 8'h00};
                    go_d = 1'b1;
                    state_d = STAT_WAIT;
                end
            end
            STAT_WAIT: if (iSPI_END) begin
                go_d = 1'b0;
                cnt_d = '0;
                mask_d = MW'(INT_MASK);
                j_d = '0;
                state_d = iS2P_DATA[DRDY_BIT] ? RD_ISSUE : IDLE;
                restart = pend_d;
            end
            RD_ISSUE: begin
                restart = pend_d;
                if (!pend_d && !iSPI_END) begin
                    p2s_d = {2'b10, DATA_BASE + {3'b000, j_q}, 8'h00};
                    go_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (iSPI_END) begin
                go_d = 1'b0;
                shadow_d[8*j_q +: 8] = iS2P_DATA;
                j_d = j_q + 3'd1;
                valid_d = j_q == LAST_J;
                data_d = (j_q == LAST_J) ? shadow_d : data_q;
                state_d = (j_q == LAST_J) ? PUBLISH : RD_ISSUE;
                restart = pend_d;
            end
            PUBLISH: state_d = IDLE;
            default: state_d = INIT_ISSUE;
        endcase
        // a re-init abandons any partial burst, so the published sample is never touched
        if (restart) begin
            state_d = INIT_ISSUE;
            idx_d = '0;
            done_d = 1'b0;
            pend_d = 1'b0;
            valid_d = 1'b0;
            data_d = data_q;
        end
    end

    always_ff @(posedge iSPI_CLK) begin
        if (iRST) begin
            state_q <= INIT_ISSUE;
            idx_q <= '0;
            j_q <= '0;
            cnt_q <= '0;
            mask_q <= '0;
            pend_q <= 1'b0;
            shadow_q <= '0;
            p2s_q <= '0;
            go_q <= 1'b0;
            data_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            j_q <= j_d;
            cnt_q <= cnt_d;
            mask_q <= mask_d;
            pend_q <= pend_d;
            shadow_q <= shadow_d;
            p2s_q <= p2s_d;
            go_q <= go_d;
            data_q <= data_d;
            valid_q <= valid_d;
            done_q <= done_d;
        end
    end

    assign oP2S_DATA = p2s_q;
    assign oSPI_GO = go_q;
    assign oDATA = data_q;
    assign oVALID = valid_q;
    assign oINIT_DONE = done_q;
endmodule

// File: tb/tb_gsensor_axis_reader.sv
// tb_gsensor_axis_reader: directed scenarios against an SPI slave stub that answers END 4 cycles after GO.
module tb_gsensor_axis_reader;
    localparam logic [223:0] TBL = {182'b0, 14'h2D08, 14'h2E80, 14'h2C09};
    localparam logic [15:0] EXP_INIT [3] = '{16'h2C09, 16'h2E80, 16'h2D08};
    localparam logic [15:0] EXP_RD [7] = '{16'hB000, 16'hB200, 16'hB300, 16'hB400, 16'hB500, 16'hB600, 16'hB700};
    localparam logic [15:0] EXP_RI [7] = '{16'hB000, 16'hB200, 16'hB300, 16'hB400, 16'h2C09, 16'h2E80, 16'h2D08};
    localparam logic [47:0] SAMPLE1 = 48'h060504030201;

    logic clk = 1'b0, rst = 1'b1, reinit = 1'b0, int2 = 1'b0, spi_end = 1'b0;
    logic go, valid, init_done, go_prev = 1'b0;
    logic [15:0] p2s;
    logic [7:0] s2p = 8'h00;
    logic [47:0] data, valid_data = '0;
    logic [7:0] regs [64];
    logic [15:0] cmd_q [$];
    int rise_q [$];
    int end_q [$];
    int cyc = 0, checks = 0, errors = 0, valid_cnt = 0, valid_cyc = -1, scnt = 0;

    gsensor_axis_reader #(
        .NUM_AXES(3), .INI_NUMBER(3), .INIT_TABLE(TBL), .DATA_BASE(6'h32),
        .INT_SOURCE_ADDR(6'h30), .DRDY_BIT(7), .IDLE_MSB(4), .INT_MASK(4)
    ) dut (
        .iSPI_CLK(clk), .iRST(rst), .iREINIT(reinit), .iG_INT2(int2),
        .oP2S_DATA(p2s), .oSPI_GO(go), .iSPI_END(spi_end), .iS2P_DATA(s2p),
        .oDATA(data), .oVALID(valid), .oINIT_DONE(init_done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin #2000000; $display("FAIL watchdog cyc=%0d required finish", cyc); $fatal(1); end

    // slave stub and monitor: cyc at a negedge names the posedge just before it
    initial forever begin
        @(negedge clk);
        if (go && !go_prev) begin
            cmd_q.push_back(p2s);
            rise_q.push_back(cyc);
            checks++;
            if (spi_end !== 1'b0) begin errors++; $display("FAIL go_during_end cyc=%0d end=%b required 0", cyc, spi_end); end
        end
        go_prev = go;
        if (valid) begin valid_cnt++; valid_cyc = cyc; valid_data = data; end
        if (!go) begin
            spi_end = 1'b0;
            scnt = 0;
        end else if (!spi_end) begin
            scnt++;
            if (scnt == 4) begin
                spi_end = 1'b1;
                s2p = p2s[15] ? regs[p2s[13:8]] : 8'h00;
                end_q.push_back(cyc + 1);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic quiet_clear;
        for (int n = 0; n < 100 && (go || spi_end); n++) tick();
        checks++;
        if (go || spi_end) begin errors++; $display("FAIL quiet go=%b end=%b required 0 0", go, spi_end); end
        cmd_q.delete(); rise_q.delete(); end_q.delete();
        valid_cnt = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go got=%b required 0", go); end
        checks++; if (p2s !== 16'h0) begin errors++; $display("FAIL reset_p2s got=%h required 0000", p2s); end
        checks++; if (data !== 48'h0) begin errors++; $display("FAIL reset_data got=%h required 0", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required 0", valid); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required 0", init_done); end
    endtask

    task automatic test_init;
        cmd_q.delete(); rise_q.delete(); end_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 300 && !init_done; i++) tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b required 1", init_done); end
        checks++; if (end_q.size() == 0 || cyc != end_q[end_q.size()-1]) begin errors++; $display("FAIL init_done_time cyc=%0d required last_end+1", cyc); end
        checks++; if (cmd_q.size() != 3) begin errors++; $display("FAIL init_count got=%0d required 3", cmd_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cmd_q.size() || cmd_q[i] !== EXP_INIT[i]) begin errors++; $display("FAIL init_cmd%0d got=%h required %h", i, (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx, EXP_INIT[i]); end
        end
    endtask

    task automatic test_data_read;
        regs[6'h30] = 8'h80;
        for (int i = 0; i < 6; i++) regs[6'h32 + i] = 8'(i + 1);
        quiet_clear();
        int2 = 1'b1;
        for (int i = 0; i < 50 && rise_q.size() < 1; i++) tick();
        int2 = 1'b0;
        for (int i = 0; i < 50 && rise_q.size() < 2; i++) tick();
        regs[6'h30] = 8'h00;
        for (int i = 0; i < 300 && valid_cnt < 1; i++) tick();
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= cmd_q.size() || cmd_q[i] !== EXP_RD[i]) begin errors++; $display("FAIL rd_cmd%0d got=%h required %h", i, (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx, EXP_RD[i]); end
        end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL rd_valid_count got=%0d required 1", valid_cnt); end
        checks++; if (valid_data !== SAMPLE1) begin errors++; $display("FAIL rd_data got=%h required %h", valid_data, SAMPLE1); end
        checks++; if (end_q.size() < 7 || valid_cyc != end_q[6]) begin errors++; $display("FAIL rd_latency valid_cyc=%0d required final_end_edge", valid_cyc); end
        checks++; if (data !== SAMPLE1) begin errors++; $display("FAIL rd_hold got=%h required %h", data, SAMPLE1); end
    endtask

    task automatic test_no_drdy;
        regs[6'h30] = 8'h00;
        quiet_clear();
        int2 = 1'b1;
        for (int i = 0; i < 100 && rise_q.size() < 3; i++) tick();
        int2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cmd_q.size() || cmd_q[i] !== 16'hB000) begin errors++; $display("FAIL nd_cmd%0d got=%h required b000", i, (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx); end
        end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL nd_valid got=%0d required 0", valid_cnt); end
        checks++; if (rise_q.size() < 3 || end_q.size() < 2 || rise_q[1] - end_q[0] != 5) begin errors++; $display("FAIL nd_mask_gap1 required 5"); end
        checks++; if (rise_q.size() < 3 || end_q.size() < 2 || rise_q[2] - end_q[1] != 5) begin errors++; $display("FAIL nd_mask_gap2 required 5"); end
    endtask

    task automatic test_timeout;
        int c;
        quiet_clear();
        for (int i = 0; i < 200 && rise_q.size() < 2; i++) tick();
        checks++; if (rise_q.size() < 2 || end_q.size() < 1 || rise_q[1] - end_q[0] != 17) begin errors++; $display("FAIL to_gap got=%0d required 17", (rise_q.size() >= 2 && end_q.size() >= 1) ? rise_q[1] - end_q[0] : -1); end
        checks++; if (cmd_q.size() < 2 || cmd_q[1] !== 16'hB000) begin errors++; $display("FAIL to_cmd required b000"); end
        for (int i = 0; i < 50 && end_q.size() < 2; i++) tick();
        c = (end_q.size() >= 2) ? end_q[1] : cyc;
        for (int i = 0; i < 100 && cyc < c + 16; i++) tick();
        int2 = 1'b1;
        for (int i = 0; i < 20 && rise_q.size() < 3; i++) tick();
        int2 = 1'b0;
        checks++; if (rise_q.size() < 3 || rise_q[2] != c + 17) begin errors++; $display("FAIL to_int_same_cycle rise=%0d required %0d", (rise_q.size() >= 3) ? rise_q[2] : -1, c + 17); end
        repeat (10) tick();
        checks++; if (rise_q.size() != 3) begin errors++; $display("FAIL to_single_poll polls=%0d required 3", rise_q.size()); end
    endtask

    task automatic test_reinit_read;
        regs[6'h30] = 8'h80;
        for (int i = 0; i < 6; i++) regs[6'h32 + i] = 8'(8'h11 + i);
        quiet_clear();
        int2 = 1'b1;
        for (int i = 0; i < 50 && rise_q.size() < 1; i++) tick();
        int2 = 1'b0;
        for (int i = 0; i < 100 && rise_q.size() < 4; i++) tick();
        regs[6'h30] = 8'h00;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        for (int i = 0; i < 50 && rise_q.size() < 5; i++) tick();
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL ri_done got=%b required 0", init_done); end
        checks++; if (data !== SAMPLE1) begin errors++; $display("FAIL ri_data got=%h required %h", data, SAMPLE1); end
        for (int i = 0; i < 300 && !init_done; i++) tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL ri_done_final got=%b required 1", init_done); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= cmd_q.size() || cmd_q[i] !== EXP_RI[i]) begin errors++; $display("FAIL ri_cmd%0d got=%h required %h", i, (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx, EXP_RI[i]); end
        end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL ri_valid got=%0d required 0", valid_cnt); end
        checks++; if (data !== SAMPLE1) begin errors++; $display("FAIL ri_data_final got=%h required %h", data, SAMPLE1); end
    endtask

    task automatic test_reset_mid;
        regs[6'h30] = 8'h80;
        quiet_clear();
        int2 = 1'b1;
        for (int i = 0; i < 50 && rise_q.size() < 1; i++) tick();
        int2 = 1'b0;
        for (int i = 0; i < 100 && rise_q.size() < 3; i++) tick();
        regs[6'h30] = 8'h00;
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL rm_go_before got=%b required 1", go); end
        rst = 1'b1;
        tick();
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL rm_go got=%b required 0", go); end
        checks++; if (p2s !== 16'h0) begin errors++; $display("FAIL rm_p2s got=%h required 0000", p2s); end
        checks++; if (data !== 48'h0) begin errors++; $display("FAIL rm_data got=%h required 0", data); end
        checks++; if (valid !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL rm_flags valid=%b done=%b required 0 0", valid, init_done); end
        tick();
        cmd_q.delete(); rise_q.delete(); end_q.delete();
        valid_cnt = 0;
        rst = 1'b0;
        for (int i = 0; i < 300 && !init_done; i++) tick();
        checks++; if (cmd_q.size() != 3) begin errors++; $display("FAIL rm_init_count got=%0d required 3", cmd_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cmd_q.size() || cmd_q[i] !== EXP_INIT[i]) begin errors++; $display("FAIL rm_init_cmd%0d got=%h required %h", i, (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx, EXP_INIT[i]); end
        end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL rm_valid got=%0d required 0", valid_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        test_reset();
        test_init();
        test_data_read();
        test_no_drdy();
        test_timeout();
        test_reinit_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
